// File: rtl/chan_scan_seq.sv
// -----------------------------------------------------------------------------
// chan_scan_seq
//
// Round-robin channel scan sequencer feeding a 2-to-4 one-hot decoder. It steps
// through four channels, holding each for dwell+1 cycles. All outputs are
// registered, so sel_out and sel_en always change on the same edge and the
// decoder never sees a valid enable with a stale index.
//
// Optional feature (compile-time macro CHAN_SCAN_SKIP_IDLE_EN):
//   defined   - channels whose req bit is clear are skipped. An empty req
//               refuses a start and ends the scan at the next advance.
//   undefined - req is ignored and the scan runs strictly 0->1->2->3->0.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    begins a scan (sampled only while idle)
//   stop     ends the scan (sampled in any state, beats start)
//   req      per-channel pending bits (only used with the skip feature)
//   dwell    hold time per channel minus one, sampled at each channel load
//   sel_out  current channel index (decoder data_in)
//   sel_en   select valid (decoder en)
//   busy     high while scanning
//   wrap     one-cycle pulse when the new index is <= the previous index
// -----------------------------------------------------------------------------
module chan_scan_seq #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [3:0]         req,
  input  logic [DWELL_W-1:0] dwell,
  output logic [1:0]         sel_out,
  output logic               sel_en,
  output logic               busy,
  output logic               wrap
);

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_t;

  state_t             state;
  logic [DWELL_W-1:0] counter;

  // Channel selection: the channel to load on a start, and the channel to
  // move to on an advance, each with a flag saying whether one exists.
  logic [1:0] first_ch;
  logic       first_ok;
  logic [1:0] next_ch;
  logic       next_ok;

`ifdef CHAN_SCAN_SKIP_IDLE_EN
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment; otherwise the unassigned paths infer latches.
    first_ch = 2'd0;
    first_ok = |req;
    next_ch  = sel_out;
    next_ok  = |req;
    // Scan downwards so the lowest set bit is the last (winning) assignment.
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) first_ch = 2'(i);
    end
    // Search order is sel_out+1, +2, +3, then sel_out itself: the default
    // above covers the self case, and +1 is assigned last so it wins.
    for (int i = 3; i >= 1; i--) begin
      if (req[2'(sel_out + 2'(i))]) next_ch = 2'(sel_out + 2'(i));
    end
  end
`else
  // req has no function in this build; fold it into an unused net.
  logic unused_req;
  assign unused_req = ^req;

  always_comb begin
    first_ch = 2'd0;
    first_ok = 1'b1;
    next_ch  = 2'(sel_out + 2'd1);
    next_ok  = 1'b1;
  end
`endif

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel_out <= 2'd0;
      sel_en  <= 1'b0;
      busy    <= 1'b0;
      wrap    <= 1'b0;
      counter <= '0;
    end else begin
      wrap <= 1'b0;
      unique case (state)
        IDLE: begin
          // sel_out keeps its last value while idle.
          if (!stop && start && first_ok) begin
            state   <= DWELL;
            sel_out <= first_ch;
            counter <= dwell;
            sel_en  <= 1'b1;
            busy    <= 1'b1;
          end
        end

        DWELL: begin
          if (stop) begin
            state  <= IDLE;
            sel_en <= 1'b0;
            busy   <= 1'b0;
          end else if (counter != '0) begin
            counter <= counter - DWELL_W'(1);
          end else if (next_ok) begin
            sel_out <= next_ch;
            counter <= dwell;
            // Reselecting the same channel counts as a wrap.
            wrap    <= (next_ch <= sel_out);
          end else begin
            state  <= IDLE;
            sel_en <= 1'b0;
            busy   <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chan_scan_seq.sv
// -----------------------------------------------------------------------------
// tb_chan_scan_seq
//
// Self-checking bench for chan_scan_seq. Each scenario task pushes the
// expected {sel_out, sel_en, busy, wrap} for every upcoming cycle into a
// queue as it drives stimulus, then pops and compares one entry per clock,
// sampling 1 ns after the rising edge. Inputs change only at that point, well
// away from the next edge. Skip-feature scenarios are built only when
// CHAN_SCAN_SKIP_IDLE_EN is defined.
// -----------------------------------------------------------------------------
module tb_chan_scan_seq;

  localparam int DWELL_W = 8;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               stop;
  logic [3:0]         req;
  logic [DWELL_W-1:0] dwell;
  logic [1:0]         sel_out;
  logic               sel_en;
  logic               busy;
  logic               wrap;

  chan_scan_seq #(.DWELL_W(DWELL_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .req     (req),
    .dwell   (dwell),
    .sel_out (sel_out),
    .sel_en  (sel_en),
    .busy    (busy),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs packed as {sel_out[1:0], sel_en, busy, wrap}.
  typedef struct {
    logic [4:0] v;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [4:0] obs();
    return {sel_out, sel_en, busy, wrap};
  endfunction

  task automatic push_exp(input logic [1:0] s, input logic en, input logic bz,
                          input logic wr, input string tag);
    exp_t e;
    e.v   = {s, en, bz, wr};
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    req   = 4'b0000;
    dwell = '0;
    for (int k = 0; k < 3; k++) push_exp(2'd0, 1'b0, 1'b0, 1'b0, $sformatf("reset_hold_%0d", k));
    for (int k = 0; k < 3; k++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        failures++;
        $display("FAIL %s got=%b want=%b", e.tag, obs(), e.v);
      end
    end
    rst_n = 1'b1;
    // Out of reset with no start: must stay idle.
    for (int k = 0; k < 2; k++) push_exp(2'd0, 1'b0, 1'b0, 1'b0, $sformatf("post_reset_idle_%0d", k));
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        failures++;
        $display("FAIL %s got=%b want=%b", e.tag, obs(), e.v);
      end
    end
  endtask

  // dwell=2: each channel held 3 cycles, wrap only when channel 0 reappears.
  task automatic test_no_skip_scan();
    exp_t e;
    dwell = 8'd2;
    req   = 4'b0000;
    start = 1'b1;
    for (int k = 0; k <= 12; k++)
      push_exp(2'((k / 3) % 4), 1'b1, 1'b1, (k == 12), $sformatf("scan_d2_k%0d", k));
    while (exp_q.size() > 0) begin
      tick();
      start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        failures++;
        $display("FAIL %s got=%b want=%b", e.tag, obs(), e.v);
      end
    end
    // Stop: enable drops on the next edge, index holds, no wrap.
    stop = 1'b1;
    push_exp(2'd0, 1'b0, 1'b0, 1'b0, "scan_d2_stop");
    tick();
    stop = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e.v) begin
      failures++;
      $display("FAIL %s got=%b want=%b", e.tag, obs(), e.v);
    end
  endtask

  // dwell=0 with start held high throughout (start ignored while scanning),
  // then start+stop together, which must leave the sequencer idle.
  task automatic test_back_to_back();
    exp_t e;
    dwell = 8'd0;
    start = 1'b1;
    for (int k = 0; k <= 5; k++)
      push_exp(2'(k % 4), 1'b1, 1'b1, (k == 4), $sformatf("b2b_d0_k%0d", k));
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        failures++;
        $display("FAIL %s got=%b want=%b", e.tag, obs(), e.v);
      end
    end
    stop = 1'b1;
    // Last channel was 1; it holds while idle.
    for (int k = 0; k < 3; k++) push_exp(2'd1, 1'b0, 1'b0, 1'b0, $sformatf("start_stop_idle_%0d", k));
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        failures++;
        $display("FAIL %s got=%b want=%b", e.tag, obs(), e.v);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Stop while the counter still holds 3.
  task automatic test_stop_mid_dwell();
    exp_t e;
    dwell = 8'd3;
    start = 1'b1;
    push_exp(2'd0, 1'b1, 1'b1, 1'b0, "stop_mid_load");
    push_exp(2'd0, 1'b0, 1'b0, 1'b0, "stop_mid_idle");
    tick();
    start = 1'b0;
    stop  = 1'b1;   // counter==3 is sampled at the coming edge
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e.v) begin
      failures++;
      $display("FAIL %s got=%b want=%b", e.tag, obs(), e.v);
    end
    tick();
    stop = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e.v) begin
      failures++;
      $display("FAIL %s got=%b want=%b", e.tag, obs(), e.v);
    end
  endtask

  // dwell 1 -> 4 during channel 0: ch0 held 2 cycles, ch1 held 5 cycles.
  task automatic test_dwell_change();
    exp_t          e;
    logic [1:0]    seq [8];
    seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    dwell = 8'd1;
    start = 1'b1;
    for (int k = 0; k < 8; k++)
      push_exp(seq[k], 1'b1, 1'b1, 1'b0, $sformatf("dwell_chg_k%0d", k));
    tick();
    start = 1'b0;
    dwell = 8'd4;
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e.v) begin
      failures++;
      $display("FAIL %s got=%b want=%b", e.tag, obs(), e.v);
    end
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        failures++;
        $display("FAIL %s got=%b want=%b", e.tag, obs(), e.v);
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (sel_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL dwell_chg_stop got en=%b busy=%b want en=0 busy=0", sel_en, busy);
    end
  endtask

  // Reset asserted mid-hold on channel 2 (counter=5): outputs clear at once,
  // nothing happens until a fresh start.
  task automatic test_reset_mid_scan();
    exp_t e;
    dwell = 8'd7;
    start = 1'b1;
    // dwell=7: 8 cycles per channel; k=18 is channel 2 with counter 5.
    for (int k = 0; k <= 18; k++)
      push_exp(2'(k / 8), 1'b1, 1'b1, 1'b0, $sformatf("rst_mid_k%0d", k));
    while (exp_q.size() > 0) begin
      tick();
      start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        failures++;
        $display("FAIL %s got=%b want=%b", e.tag, obs(), e.v);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 5'b00000) begin
      failures++;
      $display("FAIL rst_mid_async got=%b want=%b", obs(), 5'b00000);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) push_exp(2'd0, 1'b0, 1'b0, 1'b0, $sformatf("rst_mid_quiet_%0d", k));
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        failures++;
        $display("FAIL %s got=%b want=%b", e.tag, obs(), e.v);
      end
    end
    dwell = 8'd0;
    start = 1'b1;
    push_exp(2'd0, 1'b1, 1'b1, 1'b0, "rst_mid_restart");
    tick();
    start = 1'b0;
    stop  = 1'b1;
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e.v) begin
      failures++;
      $display("FAIL %s got=%b want=%b", e.tag, obs(), e.v);
    end
    tick();
    stop = 1'b0;
  endtask

`ifdef CHAN_SCAN_SKIP_IDLE_EN
  // Empty req refuses the start.
  task automatic test_skip_empty_start();
    exp_t e;
    req   = 4'b0000;
    dwell = 8'd0;
    start = 1'b1;
    push_exp(2'd0, 1'b0, 1'b0, 1'b0, "skip_empty_start");
    tick();
    start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e.v) begin
      failures++;
      $display("FAIL %s got=%b want=%b", e.tag, obs(), e.v);
    end
  endtask

  // req=1010: alternate 1,3 with wrap on each 3->1.
  task automatic test_skip_alternate();
    exp_t e;
    req   = 4'b1010;
    dwell = 8'd0;
    start = 1'b1;
    for (int k = 0; k < 6; k++)
      push_exp((k % 2 == 0) ? 2'd1 : 2'd3, 1'b1, 1'b1, (k > 0 && k % 2 == 0),
               $sformatf("skip_alt_k%0d", k));
    while (exp_q.size() > 0) begin
      tick();
      start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        failures++;
        $display("FAIL %s got=%b want=%b", e.tag, obs(), e.v);
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // req=0100: channel 2 reselected every cycle with wrap; req=0 ends the scan.
  task automatic test_skip_single();
    exp_t e;
    req   = 4'b0100;
    dwell = 8'd0;
    start = 1'b1;
    for (int k = 0; k < 4; k++)
      push_exp(2'd2, 1'b1, 1'b1, (k > 0), $sformatf("skip_one_k%0d", k));
    while (exp_q.size() > 0) begin
      tick();
      start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        failures++;
        $display("FAIL %s got=%b want=%b", e.tag, obs(), e.v);
      end
    end
    req = 4'b0000;
    push_exp(2'd2, 1'b0, 1'b0, 1'b0, "skip_one_empty_idle");
    tick();
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e.v) begin
      failures++;
      $display("FAIL %s got=%b want=%b", e.tag, obs(), e.v);
    end
  endtask
`endif

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_no_skip_scan();
    test_back_to_back();
    test_stop_mid_dwell();
    test_dwell_change();
    test_reset_mid_scan();
`ifdef CHAN_SCAN_SKIP_IDLE_EN
    test_skip_empty_start();
    test_skip_alternate();
    test_skip_single();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
